md5_match_checker: RTL

- Downstream of the pancham MD5 core in the MD5Controller datapath; consumes its hashed output and decides whether the brute-force search has succeeded.
- Holds every in-flight plaintext guess in an ordered tag FIFO. Entries are pushed when the encrypter accepts a word and popped when the matching digest emerges.
- Compares each digest against target_hash; on a match, latches the originating plaintext and raises a sticky hashes_equal to stop the search.

---
 rtl/md5_match_checker.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/md5_match_checker.sv
// Match checker behind the pancham MD5 core: tracks in-flight guesses and flags the matching one.
// Optional hashes_checked counter is enabled with `define MD5_MATCH_STATS_EN.
module md5_match_checker #(
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned PTR_W   = 3,
  parameter int unsigned COUNT_W = 32
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [127:0]       target_hash,
  input  logic [127:0]       guess_in,
  input  logic               guess_push,
  input  logic [127:0]       hash_in,
  input  logic               hash_valid,
  output logic               fifo_full,
  output logic               done,
  output logic               hashes_equal,
  output logic [127:0]       plaintext,
  output logic [COUNT_W-1:0] hashes_checked,
  output logic               overflow_err,
  output logic               underflow_err
);

  localparam logic [PTR_W:0] DepthCnt = (PTR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {StSearching, StFound, StFault} state_e;

  state_e           state_q, state_d;
  logic [127:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   count_q, count_d;

  logic             stg_valid_q;
  logic [127:0]     stg_guess_q;
  logic [127:0]     stg_hash_q;

  logic             fifo_full_q, done_q, hashes_equal_q, overflow_q, underflow_q;
  logic [127:0]     plaintext_q;

  logic searching, full, empty, pop, push, ovf, unf, compare_en, stg_match;

  always_comb begin
    searching  = (state_q == StSearching);
    full       = (count_q == DepthCnt);
    empty      = (count_q == '0);
    pop        = searching && hash_valid && !empty;
    push       = searching && guess_push && (!full || pop);
    ovf        = searching && guess_push && full && !hash_valid;
    unf        = searching && hash_valid && empty;
    // A stage loaded just before FAULT still finishes; once FOUND the result is frozen.
    compare_en = stg_valid_q && (state_q != StFound);
    stg_match  = compare_en && (stg_hash_q == target_hash);
  end

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + (PTR_W + 1)'(1);
    end else if (pop && !push) begin
      count_d = count_q - (PTR_W + 1)'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    if (searching) begin
      if (stg_match) begin
        state_d = StFound;
      end else if (ovf || unf) begin
        state_d = StFault;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= StSearching;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      stg_valid_q    <= 1'b0;
      stg_guess_q    <= '0;
      stg_hash_q     <= '0;
      fifo_full_q    <= 1'b0;
      done_q         <= 1'b0;
      hashes_equal_q <= 1'b0;
      plaintext_q    <= '0;
      overflow_q     <= 1'b0;
      underflow_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      fifo_full_q <= (state_d != StSearching) || (count_d == DepthCnt);
      done_q      <= (state_d != StSearching);
      stg_valid_q <= pop;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q    <= rd_ptr_q + PTR_W'(1);
        stg_guess_q <= mem_q[rd_ptr_q];
        stg_hash_q  <= hash_in;
      end
      if (stg_match) begin
        plaintext_q    <= stg_guess_q;
        hashes_equal_q <= 1'b1;
      end
      if (ovf) begin
        overflow_q <= 1'b1;
      end
      if (unf) begin
        underflow_q <= 1'b1;
      end
    end
  end

  // Tag storage needs no reset: pointers and count define what is live.
  always_ff @(posedge clock) begin
    if (push) begin
      mem_q[wr_ptr_q] <= guess_in;
    end
  end

`ifdef MD5_MATCH_STATS_EN
  logic [COUNT_W-1:0] checked_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      checked_q <= '0;
    end else if (compare_en && (checked_q != '1)) begin
      checked_q <= checked_q + COUNT_W'(1);
    end
  end

  assign hashes_checked = checked_q;
`else
  assign hashes_checked = '0;
`endif

  assign fifo_full     = fifo_full_q;
  assign done          = done_q;
  assign hashes_equal  = hashes_equal_q;
  assign plaintext     = plaintext_q;
  assign overflow_err  = overflow_q;
  assign underflow_err = underflow_q;

endmodule
